// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic output drain/requantization path.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;

  typedef logic signed [31:0] acc_t;
  typedef logic signed [7:0]  q8_t;

  localparam int Q8_MAX     = 127;
  localparam int Q8_MIN     = -128;
  localparam int PROD_WIDTH = 48;
  localparam int MAX_SHIFT  = 47;

endpackage

// File: rtl/requant_lane.sv
// One requantization lane: exact product for S0, then round-half-up, arithmetic shift
// and int8 saturation of a registered product for S1. Purely combinational.
module requant_lane
  import systolic_pkg::*;
#(
  parameter int MULT_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 6
) (
  input  acc_t                          acc_i,
  input  logic signed [MULT_WIDTH-1:0]  mult_i,
  output logic signed [PROD_WIDTH-1:0]  prod_o,
  input  logic signed [PROD_WIDTH-1:0]  prod_i,
  input  logic [SHIFT_WIDTH-1:0]        shift_i,
  output q8_t                           q_o
);

  logic [SHIFT_WIDTH-1:0]       effShift;
  logic [PROD_WIDTH:0]          roundBit;
  logic signed [PROD_WIDTH:0]   sum;
  logic signed [PROD_WIDTH:0]   shifted;

  // One extra bit on the sum: the largest product plus the largest rounding term reaches 2^47.
  always_comb begin
    prod_o   = $signed({{(PROD_WIDTH-32){acc_i[31]}}, acc_i}) *
               $signed({{(PROD_WIDTH-MULT_WIDTH){mult_i[MULT_WIDTH-1]}}, mult_i});
    effShift = (shift_i > SHIFT_WIDTH'(MAX_SHIFT)) ? SHIFT_WIDTH'(MAX_SHIFT) : shift_i;
    roundBit = '0;
    if (effShift != '0) roundBit[effShift - 1'b1] = 1'b1;
    sum      = $signed({prod_i[PROD_WIDTH-1], prod_i}) + $signed(roundBit);
    shifted  = sum >>> effShift;
    if (shifted > (PROD_WIDTH+1)'(Q8_MAX))      q_o = q8_t'(Q8_MAX);
    else if (shifted < (PROD_WIDTH+1)'(Q8_MIN)) q_o = q8_t'(Q8_MIN);
    else                                        q_o = q8_t'(shifted[7:0]);
  end

endmodule

// File: rtl/systolic_requant_drain.sv
// Drains a finished tile from the systolic output buffer, requantizes every lane to int8
// and streams rows out through a credit-protected show-ahead skid FIFO.
module systolic_requant_drain
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH        = 8,
  parameter int DATAWIDTH_output = 32,
  parameter int N_SIZE           = 32,
  parameter int BUS_WIDTH        = 256,
  parameter int ADDR_WIDTH       = 10,
  parameter int MULT_WIDTH       = 16,
  parameter int SHIFT_WIDTH      = 6,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [ADDR_WIDTH:0]                num_rows,
  input  logic [MULT_WIDTH-1:0]              scale_mult,
  input  logic [SHIFT_WIDTH-1:0]             scale_shift,
  output logic [ADDR_WIDTH-1:0]              rd_addr_outbuffer,
  input  logic [DATAWIDTH_output*N_SIZE-1:0] rd_data_outbuffer,
  output logic [BUS_WIDTH-1:0]               out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t                       state_q;
  logic [ADDR_WIDTH-1:0]        rdAddr_q;
  logic [ADDR_WIDTH:0]          rowsLeft_q;
  logic signed [MULT_WIDTH-1:0] mult_q;
  logic [SHIFT_WIDTH-1:0]       shift_q;
  logic                         busy_q, done_q;
  logic                         s0Valid_q, s1Valid_q;

  logic signed [PROD_WIDTH-1:0] prod_d [N_SIZE];
  logic signed [PROD_WIDTH-1:0] prod_q [N_SIZE];
  logic [BUS_WIDTH-1:0]         row_d;

  logic [BUS_WIDTH-1:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]             wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]             count_q;

  logic [CNT_W-1:0]             inFlight;
  logic                         issue, fifoPush, fifoPop, lastBeat;

  for (genvar i = 0; i < N_SIZE; i++) begin : gLane
    requant_lane #(
      .MULT_WIDTH (MULT_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) uLane (
      .acc_i  (rd_data_outbuffer[i*DATAWIDTH_output +: DATAWIDTH_output]),
      .mult_i (mult_q),
      .prod_o (prod_d[i]),
      .prod_i (prod_q[i]),
      .shift_i(shift_q),
      .q_o    (row_d[i*DATAWIDTH +: DATAWIDTH])
    );
  end

  // Everything not yet popped counts against the FIFO, so a push can never find it full.
  always_comb begin
    fifoPush = s1Valid_q;
    fifoPop  = out_valid && out_ready;
    inFlight = count_q + CNT_W'(s0Valid_q) + CNT_W'(s1Valid_q);
    issue    = (state_q == ISSUE) && (inFlight < CNT_W'(FIFO_DEPTH));
    lastBeat = fifoPop && (count_q == CNT_W'(1)) && !s0Valid_q && !s1Valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rdAddr_q   <= '0;
      rowsLeft_q <= '0;
      mult_q     <= '0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            rdAddr_q   <= base_addr;
            rowsLeft_q <= num_rows;
            mult_q     <= scale_mult;
            shift_q    <= scale_shift;
            busy_q     <= 1'b1;
            state_q    <= (num_rows == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            rdAddr_q   <= rdAddr_q + 1'b1;
            rowsLeft_q <= rowsLeft_q - 1'b1;
            if (rowsLeft_q == (ADDR_WIDTH+1)'(1)) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (lastBeat) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // An empty tile arrives here without a pending pulse and spends one extra cycle.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0Valid_q <= 1'b0;
      s1Valid_q <= 1'b0;
      for (int i = 0; i < N_SIZE; i++) prod_q[i] <= '0;
    end else begin
      s0Valid_q <= issue;
      s1Valid_q <= s0Valid_q;
      if (s0Valid_q) prod_q <= prod_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (fifoPush) begin
        mem_q[wrPtr_q] <= row_d;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (fifoPop) rdPtr_q <= rdPtr_q + 1'b1;
      case ({fifoPush, fifoPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_addr_outbuffer = rdAddr_q;
  assign out_data          = mem_q[rdPtr_q];
  assign out_valid         = (count_q != '0);
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_systolic_requant_drain.sv
// Self-checking bench: behavioural output-buffer model plus a plain-arithmetic requant reference.
module tb_systolic_requant_drain;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [9:0]    base_addr;
  logic [10:0]   num_rows;
  logic [15:0]   scale_mult;
  logic [5:0]    scale_shift;
  logic [9:0]    rd_addr_outbuffer;
  logic [1023:0] rd_data_outbuffer;
  logic [255:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int asserts  = 0;
  int failures = 0;
  int bufMem [1024][32];

  systolic_requant_drain dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .base_addr        (base_addr),
    .num_rows         (num_rows),
    .scale_mult       (scale_mult),
    .scale_shift      (scale_shift),
    .rd_addr_outbuffer(rd_addr_outbuffer),
    .rd_data_outbuffer(rd_data_outbuffer),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  function automatic logic [1023:0] packRow(input logic [9:0] a);
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = bufMem[a][i];
    return r;
  endfunction

  // Output buffer: synchronous read, data one cycle after the address.
  always @(posedge clk) rd_data_outbuffer <= packRow(rd_addr_outbuffer);

  function automatic logic [7:0] refRequant(input int acc, input int m, input int s);
    longint p;
    int     sh;
    p  = longint'(acc) * longint'(m);
    sh = (s > 47) ? 47 : s;
    if (sh > 0) p = (p + (longint'(1) << (sh - 1))) >>> sh;
    if (p > 127) p = 127;
    else if (p < -128) p = -128;
    return p[7:0];
  endfunction

  function automatic logic [255:0] expRow(input logic [9:0] a, input int m, input int s);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = refRequant(bufMem[a][i], m, s);
    return r;
  endfunction

  task automatic fillRandom(input logic [9:0] a);
    for (int i = 0; i < 32; i++) bufMem[a][i] = int'($urandom_range(0, 60000)) - 30000;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    asserts++;
    assert (obs === expv)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Pulses start, then scrambles the parameters to show they were latched.
  task automatic applyStimulus(input logic [9:0] b, input logic [10:0] n,
                               input logic [15:0] m, input logic [5:0] s);
    start       = 1'b1;
    base_addr   = b;
    num_rows    = n;
    scale_mult  = m;
    scale_shift = s;
    @(posedge clk);
    @(negedge clk);
    start       = 1'b0;
    base_addr   = 10'($urandom);
    num_rows    = 11'($urandom_range(1, 40));
    scale_mult  = 16'($urandom);
    scale_shift = 6'($urandom);
  endtask

  task automatic runTile(input logic [9:0] b, input logic [10:0] n, input logic [15:0] m,
                         input logic [5:0] s, input bit randReady, input int restartAt,
                         input int abortAfter, output int firstValid, output int doneCyc,
                         output logic [255:0] firstBeat);
    logic [255:0] expQ[$];
    logic [255:0] prevData;
    bit           prevStall = 0;
    bit           finished  = 0;
    bit           aborted   = 0;
    int           beats     = 0;
    int           cyc       = 1;
    logic [9:0]   issued;
    for (int k = 0; k < int'(n); k++) expQ.push_back(expRow(10'(int'(b) + k), int'($signed(m)), int'(s)));
    firstValid = -1;
    doneCyc    = -1;
    firstBeat  = '0;
    prevData   = '0;
    applyStimulus(b, n, m, s);
    while (!finished && cyc <= 300) begin
      if (abortAfter >= 0 && beats == abortAfter) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_valid", out_valid, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        rst      = 1'b0;
        aborted  = 1;
        finished = 1;
      end else begin
        out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        start     = (cyc == restartAt);
        if (prevStall) begin
          checkOutput("stall_valid", out_valid, 1'b1);
          checkOutput("stall_data", out_data, prevData);
        end
        issued = rd_addr_outbuffer - b;
        checkOutput("inflight_le4", 256'(int'(issued) - beats <= 4), 256'(1));
        if (out_valid && firstValid < 0) firstValid = cyc;
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) checkOutput("beat_overrun", beats, int'(n) - 1);
          else begin
            if (beats == 0) firstBeat = out_data;
            checkOutput($sformatf("row%0d", beats), out_data, expQ.pop_front());
          end
          beats++;
        end
        prevStall = out_valid && !out_ready;
        prevData  = out_data;
        if (done) begin
          doneCyc  = cyc;
          finished = 1;
        end else begin
          @(posedge clk);
          @(negedge clk);
          cyc++;
        end
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    checkOutput("finished", finished, 1'b1);
    if (finished && !aborted) begin
      checkOutput("beats", beats, n);
      checkOutput("leftover", expQ.size(), 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("done_pulse", done, 1'b0);
      checkOutput("busy_after", busy, 1'b0);
    end
  endtask

  initial begin
    int           fv, dc;
    logic [255:0] fb;
    rst         = 1'b1;
    start       = 1'b0;
    base_addr   = '0;
    num_rows    = '0;
    scale_mult  = '0;
    scale_shift = '0;
    out_ready   = 1'b1;
    for (int a = 0; a < 1024; a++) for (int i = 0; i < 32; i++) bufMem[a][i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_addr", rd_addr_outbuffer, 10'd0);
    checkOutput("rst_data", out_data, 256'd0);
    checkOutput("rst_valid", out_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic drain");
    for (int k = 0; k < 4; k++) for (int i = 0; i < 32; i++) bufMem[k][i] = k;
    runTile(10'd0, 11'd4, 16'd1, 6'd0, 0, -1, -1, fv, dc, fb);
    checkOutput("basic_first_valid", fv, 4);
    checkOutput("basic_done_cycle", dc, 8);

    $display("[TB] rounding and saturation");
    fillRandom(10'd100);
    bufMem[100][0] = 100; bufMem[100][1] = 1000; bufMem[100][2] = -1000;
    runTile(10'd100, 11'd1, 16'd3, 6'd2, 0, -1, -1, fv, dc, fb);
    checkOutput("rq_100x3s2", fb[7:0], 8'd75);
    checkOutput("rq_1000x3s2", fb[15:8], 8'd127);
    checkOutput("rq_m1000x3s2", fb[23:16], 8'h80);
    fillRandom(10'd101);
    bufMem[101][0] = -6; bufMem[101][1] = 6;
    runTile(10'd101, 11'd1, 16'd1, 6'd2, 0, -1, -1, fv, dc, fb);
    checkOutput("rq_m6s2", fb[7:0], 8'hFF);
    checkOutput("rq_6s2", fb[15:8], 8'd2);
    fillRandom(10'd102);
    bufMem[102][0] = 1000; bufMem[102][1] = -1000; bufMem[102][2] = 5;
    runTile(10'd102, 11'd1, 16'd1, 6'd0, 0, -1, -1, fv, dc, fb);
    checkOutput("rq_sat_hi", fb[7:0], 8'd127);
    checkOutput("rq_sat_lo", fb[15:8], 8'h80);
    checkOutput("rq_pass5", fb[23:16], 8'd5);
    fillRandom(10'd103);
    bufMem[103][0] = int'(32'h8000_0000); bufMem[103][1] = int'(32'h7FFF_FFFF);
    runTile(10'd103, 11'd1, 16'h8000, 6'd60, 0, -1, -1, fv, dc, fb);
    checkOutput("rq_clamp_max", fb[7:0], 8'd1);
    checkOutput("rq_clamp_neg", fb[15:8], 8'd0);

    $display("[TB] backpressure");
    for (int k = 200; k < 216; k++) fillRandom(10'(k));
    runTile(10'd200, 11'd16, 16'(int'($urandom_range(0, 600)) - 300), 6'd4, 1, -1, -1, fv, dc, fb);
    for (int k = 220; k < 232; k++) fillRandom(10'(k));
    runTile(10'd220, 11'd12, 16'($urandom), 6'($urandom), 1, -1, -1, fv, dc, fb);

    $display("[TB] address wrap and empty tile");
    fillRandom(10'd1022); fillRandom(10'd1023); fillRandom(10'd0); fillRandom(10'd1);
    runTile(10'd1022, 11'd4, 16'd7, 6'd3, 0, -1, -1, fv, dc, fb);
    checkOutput("wrap_done_cycle", dc, 8);
    runTile(10'd500, 11'd0, 16'd1, 6'd0, 0, -1, -1, fv, dc, fb);
    checkOutput("zero_done_cycle", dc, 2);
    checkOutput("zero_no_valid", fv, -1);
    checkOutput("zero_addr_held", rd_addr_outbuffer, 10'd500);

    $display("[TB] start while busy, then mid-run reset");
    for (int k = 300; k < 306; k++) fillRandom(10'(k));
    runTile(10'd300, 11'd6, 16'd9, 6'd5, 0, 2, -1, fv, dc, fb);
    checkOutput("restart_done_cycle", dc, 10);
    repeat (4) begin
      @(negedge clk);
      checkOutput("restart_idle_busy", busy, 1'b0);
      checkOutput("restart_idle_valid", out_valid, 1'b0);
    end
    for (int k = 400; k < 410; k++) fillRandom(10'(k));
    runTile(10'd400, 11'd10, 16'd11, 6'd6, 0, -1, 3, fv, dc, fb);
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_no_done", done, 1'b0);
    end
    runTile(10'd400, 11'd5, 16'd13, 6'd6, 1, -1, -1, fv, dc, fb);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
